xgmii_tx_pace_ctrl: RTL
=======================

// Module: xgmii_tx_pace_ctrl
// PURPOSE
//  TX pacing controller between the MAC TX path and the 64b/66b PCS.
//  Drives the MAC's xgmii pause input with the 32/33 gearbox pattern (one stall per
//  GEARBOX_PERIOD cycles). Monitors the MAC XGMII output for frame boundaries.
//  Enforces 802.3x PAUSE: when a quanta count arrives from the RX MAC, the current
//  frame completes, then new frame starts are held off until the timer expires.
// PARAMETERS
//  XGMII_DATA_WIDTH  32  XGMII data width; only 32 is supported
//  XGMII_CTRL_WIDTH  4   XGMII control width, one bit per lane
//  GEARBOX_EN        1   1 = generate gearbox stalls; 0 = pause output tied low
//  GEARBOX_PERIOD    33  sequence length; pause is high in the last count
//  QUANTA_CYCLES     16  clk cycles per pause quantum (512 bit-times / 32 bits)
// PORTS
//  clk            in   1   core clock; single clock domain
//  i_reset        in   1   synchronous, active-high reset
//  i_xgmii_txd    in   32  MAC TX XGMII data (monitored only)
//  i_xgmii_ctrl   in   4   MAC TX XGMII control (monitored only)
//  i_xgmii_valid  in   1   MAC TX XGMII word valid
//  i_fc_enable    in   1   PAUSE honouring enable; low clears the timer
//  i_fc_valid     in   1   1-cycle strobe: received PAUSE quanta valid
//  i_fc_quanta    in   16  PAUSE quanta value; 0 = resume
//  o_xgmii_pause  out  1   to MAC pause input: MAC holds its output word this cycle
//  o_gb_seq       out  6   gearbox sequence count 0..GEARBOX_PERIOD-1, to PCS
//  o_tx_hold      out  1   to TX frame source: do not start a new frame
//  o_fc_active    out  1   PAUSE timer non-zero
// BEHAVIOUR
//  Reset: seq=0, timer=0, state=IDLE; all outputs 0. Reset wins over every other input.
//  Gearbox
//   - seq increments every cycle; after GEARBOX_PERIOD-1 it wraps to 0.
//   - o_xgmii_pause = (seq==GEARBOX_PERIOD-1), decoded from the seq register.
//   - GEARBOX_EN=0: seq is held at 0 and pause is held at 0.
//  Frame detect (qualified by i_xgmii_valid)
//   - start: ctrl[0]=1 and txd[7:0]=8'hFB.
//   - term: any lane j with ctrl[j]=1 and txd[8j+:8]=8'hFD.
//  PAUSE timer (16+4 bits)
//   - On i_fc_valid && i_fc_enable: load quanta*QUANTA_CYCLES. A load overrides a
//     decrement in the same cycle.
//   - Otherwise, decrement by 1 when timer!=0 and o_xgmii_pause=0. Stall cycles do
//     not count as bit-times. The timer runs in every state. No underflow.
//   - i_fc_enable=0: timer cleared next cycle.
//  FSM (tx_fc_state_t)
//   - IDLE    : start -> IN_FRAME; else timer!=0 -> HOLD.
//   - IN_FRAME: term -> HOLD if the next timer value is !=0, else IDLE.
//     A start seen in IN_FRAME is ignored.
//   - HOLD    : timer==0 -> IDLE. A start seen in HOLD (source violation) -> IN_FRAME.
//  Outputs (registered, 1-cycle latency from the causing input)
//   - o_tx_hold = (next_state==HOLD).
//   - o_fc_active = (next_timer!=0).
//  Boundary rules
//   - start and fc load in the same IDLE cycle: the frame proceeds; hold begins the
//     cycle after term.
//   - A term in IDLE/HOLD (orphan after a mid-frame reset) is ignored.
//   - quanta=0 while in HOLD: next cycle is IDLE and o_tx_hold=0.
// STRUCTURE
//  Add to mac_pkg:
//   - XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_IDLE=8'h07.
//   - typedef enum logic[1:0] {FC_IDLE, FC_IN_FRAME, FC_HOLD} tx_fc_state_t.
//  Sub-module xgmii_gb_seq: the wrap counter plus pause decode (GEARBOX_EN,
//  GEARBOX_PERIOD). The PCS gearbox reuses it.
//  The top level contains the frame detect logic, the timer and the FSM.
// TESTING
//  1. Release reset, idle 100 cycles -> pause high exactly on cycles 32, 65, 98;
//     o_gb_seq runs 0..32 and wraps; hold=0.
//  2. Start, then quanta=2 strobe mid-frame, term 10 cycles later -> hold=0 until the
//     cycle after term. Hold then stays high for the remaining 32-count of
//     non-stall cycles and drops when the timer reaches 0.
//  3. quanta=100 in IDLE, then quanta=0 while in HOLD -> o_tx_hold and o_fc_active
//     fall one cycle after the second strobe.
//  4. fc strobe (quanta=1) in the same cycle as start -> IN_FRAME, hold=0 until term.
//     The timer (16) decrements during the frame; hold is asserted only if the
//     remaining count is >0 at term.
//  5. i_reset mid-frame with timer loaded -> all outputs 0 the next cycle; the
//     following orphan term does not change state; the next start is tracked.
//  6. GEARBOX_EN=0, quanta=1 -> pause never asserts; hold lasts exactly 16 cycles.
//     i_fc_enable=0 with a strobe -> no hold.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC constants, TX pacing FSM state type and XGMII decode helpers
package mac_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;

  localparam int XGMII_LANES = 4;
  localparam int FC_TIMER_W  = 20;

  typedef enum logic [1:0] {
    FC_IDLE,
    FC_IN_FRAME,
    FC_HOLD
  } tx_fc_state_t;

  function automatic logic xgmii_is_start(input logic [31:0] txd, input logic [3:0] ctrl);
    return ctrl[0] && (txd[7:0] == XGMII_START);
  endfunction

  // A terminate may sit in any lane, depending on frame length modulo 4.
  function automatic logic xgmii_has_term(input logic [31:0] txd, input logic [3:0] ctrl);
    logic found;
    found = 1'b0;
    for (int j = 0; j < XGMII_LANES; j++) begin
      if (ctrl[j] && (txd[8*j +: 8] == XGMII_TERM)) begin
        found = 1'b1;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/xgmii_gb_seq.sv
// rtl/xgmii_gb_seq.sv - 64b/66b gearbox sequence counter with stall decode
module xgmii_gb_seq #(
  parameter int GEARBOX_EN     = 1,
  parameter int GEARBOX_PERIOD = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] seq,
  output logic       pause
);

  localparam logic [5:0] LAST = 6'(GEARBOX_PERIOD - 1);

  always_ff @(posedge clk) begin
    if (reset || (GEARBOX_EN == 0)) begin
      seq <= '0;
    end else if (seq == LAST) begin
      seq <= '0;
    end else begin
      seq <= seq + 6'd1;
    end
  end

  // Decoded from the register so the stall lines up with the count the PCS sees.
  assign pause = (GEARBOX_EN != 0) && (seq == LAST);

endmodule

// File: rtl/xgmii_tx_pace_ctrl.sv
// rtl/xgmii_tx_pace_ctrl.sv - TX pacing: gearbox stalls, frame tracking and 802.3x PAUSE hold-off
module xgmii_tx_pace_ctrl
  import mac_pkg::*;
#(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_CTRL_WIDTH = 4,
  parameter int GEARBOX_EN       = 1,
  parameter int GEARBOX_PERIOD   = 33,
  parameter int QUANTA_CYCLES    = 16
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_txd,
  input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
  input  logic                        i_xgmii_valid,
  input  logic                        i_fc_enable,
  input  logic                        i_fc_valid,
  input  logic [15:0]                 i_fc_quanta,
  output logic                        o_xgmii_pause,
  output logic [5:0]                  o_gb_seq,
  output logic                        o_tx_hold,
  output logic                        o_fc_active
);

  tx_fc_state_t            state;
  tx_fc_state_t            state_next;
  logic [FC_TIMER_W-1:0]   timer;
  logic [FC_TIMER_W-1:0]   timer_next;
  logic                    start;
  logic                    term;

  xgmii_gb_seq #(
    .GEARBOX_EN     (GEARBOX_EN),
    .GEARBOX_PERIOD (GEARBOX_PERIOD)
  ) u_gb_seq (
    .clk   (clk),
    .reset (i_reset),
    .seq   (o_gb_seq),
    .pause (o_xgmii_pause)
  );

  always_comb begin
    start = i_xgmii_valid && xgmii_is_start(i_xgmii_txd, i_xgmii_ctrl);
    term  = i_xgmii_valid && xgmii_has_term(i_xgmii_txd, i_xgmii_ctrl);
  end

  // Stall cycles carry no bit-times, so the quantum countdown skips them.
  always_comb begin
    timer_next = timer;
    if (!i_fc_enable) begin
      timer_next = '0;
    end else if (i_fc_valid) begin
      timer_next = FC_TIMER_W'(i_fc_quanta) * FC_TIMER_W'(QUANTA_CYCLES);
    end else if ((timer != '0) && !o_xgmii_pause) begin
      timer_next = timer - FC_TIMER_W'(1);
    end
  end

  // Decisions look at the post-update timer so a quanta=0 resume releases hold at once.
  always_comb begin
    state_next = state;
    case (state)
      FC_IDLE: begin
        if (start) begin
          state_next = FC_IN_FRAME;
        end else if (timer_next != '0) begin
          state_next = FC_HOLD;
        end
      end
      FC_IN_FRAME: begin
        if (term) begin
          state_next = (timer_next != '0) ? FC_HOLD : FC_IDLE;
        end
      end
      FC_HOLD: begin
        if (start) begin
          state_next = FC_IN_FRAME;
        end else if (timer_next == '0) begin
          state_next = FC_IDLE;
        end
      end
      default: state_next = FC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= FC_IDLE;
      timer       <= '0;
      o_tx_hold   <= 1'b0;
      o_fc_active <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      o_tx_hold   <= (state_next == FC_HOLD);
      o_fc_active <= (timer_next != '0);
    end
  end

endmodule
